rr_onehot_arbiter: RTL and testbench
====================================

Name: rr_onehot_arbiter

Overview:
- Round-robin arbiter that produces the one-hot select that a downstream one-hot mux consumes. It also produces a binary index of the same grant.
- Sits between WIDTH requesters (e.g. functional-unit or CDB broadcast sources) and the shared one-hot mux feeding a shared resource.
- Grants are registered and held until the consumer acknowledges. Fairness comes from a rotating priority pointer.

Parameters:
- WIDTH, 4, number of requesters; must be >= 2, need not be a power of 2.
- IDX_W, $clog2(WIDTH), width of the binary grant index and the priority pointer.

Ports:
- clock  input  1  system clock; all state updates on the posedge.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  WIDTH  per-requester request level; a requester holds req high until its grant is acked.
- ack  input  1  consumer accepted the current grant this cycle; ignored when grant_valid=0.
- grant  output  WIDTH  registered one-hot grant; all zeros when grant_valid=0.
- grant_valid  output  1  grant holds a live one-hot value.
- grant_idx  output  IDX_W  binary index of the set bit of grant; 0 when grant_valid=0.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (reset_n=0, async, any time, including mid-grant):
  - grant=0, grant_valid=0, grant_idx=0, ptr=0, state=IDLE.
  - No grant is issued on the first posedge after deassertion unless req is nonzero at that edge.
- State: IDLE, GRANTED. Internal ptr (IDX_W bits) is the highest-priority index.
- Selection function: pick the first index i with req[i]=1, scanning ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1. Wrap is modulo WIDTH, not 2^IDX_W.
- IDLE:
  - req=0: stay IDLE, outputs stay 0.
  - req!=0: at the next posedge, grant<=onehot(sel), grant_idx<=sel, grant_valid<=1, state<=GRANTED.
  - Latency is 1 cycle from req to grant.
- GRANTED, ack=0:
  - grant and grant_idx are held bit-stable regardless of req changes.
  - A requester dropping req while granted is a protocol violation; the arbiter keeps the grant anyway.
- GRANTED, ack=1, with g = current grant_idx:
  - ptr <= (g+1) mod WIDTH.
  - Re-select with the scan starting at (g+1) mod WIDTH. The current grantee is therefore lowest priority, but is still selected if it is the only requester.
  - If a selection exists: new grant loads at the same edge (back-to-back, no bubble), stay GRANTED.
  - Otherwise: grant/grant_idx/grant_valid <= 0, state <= IDLE.
- ptr changes only on an acked grant. IDLE never moves ptr.
- Wrap: g=WIDTH-1 acked gives ptr=0.
- Invariant: grant is always zero or exactly one-hot, and grant[grant_idx]=1 whenever grant_valid=1.
- Combinational paths: none from req/ack to outputs. All outputs are flops.

Optional Feature:
- Macro: RR_ARB_LOCK_EN.
- Defined:
  - Adds port lock (input, 1): the grantee wants to keep ownership for a multi-beat transfer.
  - On ack=1 with lock=1 in GRANTED: grant, grant_idx and ptr are unchanged, state stays GRANTED, even if other requests are pending.
  - On ack=1 with lock=0: normal rotation.
  - lock is ignored in IDLE.
- Undefined: the lock port does not exist, and every ack rotates as described above.

Test Plan:
- Reset then idle: reset_n=0 for 2 cycles, then 1 with req=0000 for 5 cycles -> grant=0000, grant_valid=0, grant_idx=0 throughout.
- Single requester:
  - req=0100 at cycle 0 -> cycle 1 grant=0100, grant_idx=2, valid=1.
  - Held for 3 cycles with ack=0.
  - ack=1 with req dropped to 0000 -> next cycle valid=0, grant=0000.
- Full rotation: req=1111, ack=1 every cycle -> grants in order 0001, 0010, 0100, 1000, 0001, with no bubble cycles and ptr wrapping 3 to 0.
- Fairness skip: ptr=1 after granting idx 0, req=1001 -> next grant=1000 (idx 3). After its ack -> grant=0001 (idx 0).
- Async reset mid-grant: grant=0010 valid; pulse reset_n low between clock edges -> outputs 0 immediately, before the next posedge. After release with req=0010 -> grant=0010 one cycle later, ptr restarted at 0.
- RR_ARB_LOCK_EN (compiled in): req=0011, grant=0001. ack=1 with lock=1 for 3 cycles -> grant stays 0001. ack=1 with lock=0 -> grant=0010.

Source files
------------

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot grant plus its binary index.
// Optional feature macro RR_ARB_LOCK_EN adds a 'lock' input that keeps ownership across acks.
module rr_onehot_arbiter #(
  parameter int WIDTH = 4,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] req,
  input  logic             ack,
`ifdef RR_ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [WIDTH-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic             state_dbg,
  output logic [IDX_W-1:0] ptr_dbg
);

  // Handshake: grant/grant_idx are presented while grant_valid=1 and stay stable
  // until the consumer pulses ack; ack with grant_valid=0 has no effect.
  typedef enum logic {IDLE = 1'b0, GRANTED = 1'b1} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] scan_start;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_found;
  logic             rotate;

  // Modulo-WIDTH increment so non-power-of-2 widths wrap correctly.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= WIDTH) s = s - WIDTH;
    return IDX_W'(s);
  endfunction

  always_comb begin
    scan_start = (state == GRANTED) ? wrap_add(grant_idx, 1) : ptr;
  end

  // Walk the scan order backwards so the earliest hit overwrites later ones.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (req[wrap_add(scan_start, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_add(scan_start, k);
      end
    end
  end

`ifdef RR_ARB_LOCK_EN
  always_comb rotate = ack && !lock;
`else
  always_comb rotate = ack;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      ptr         <= '0;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant       <= WIDTH'(1) << sel_idx;
            grant_idx   <= sel_idx;
            grant_valid <= 1'b1;
            state       <= GRANTED;
          end
        end
        GRANTED: begin
          if (rotate) begin
            ptr <= wrap_add(grant_idx, 1);
            if (sel_found) begin
              grant     <= WIDTH'(1) << sel_idx;
              grant_idx <= sel_idx;
            end else begin
              grant       <= '0;
              grant_idx   <= '0;
              grant_valid <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign state_dbg = (state == GRANTED);
  assign ptr_dbg   = ptr;

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Bench for rr_onehot_arbiter: directed vector table, hand sequences for reset and lock,
// and randomized traffic checked against a modulo-arithmetic reference model.
module tb_rr_onehot_arbiter;
  localparam int WIDTH = 4;
  localparam int IDX_W = 2;

  logic             clock = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] req;
  logic             ack;
  logic             lock;
  logic [WIDTH-1:0] grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;
  logic             state_dbg;
  logic [IDX_W-1:0] ptr_dbg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  rr_onehot_arbiter #(.WIDTH(WIDTH)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req),
    .ack         (ack),
`ifdef RR_ARB_LOCK_EN
    .lock        (lock),
`endif
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx),
    .state_dbg   (state_dbg),
    .ptr_dbg     (ptr_dbg)
  );

  typedef struct {
    logic             rst;
    logic [WIDTH-1:0] req;
    logic             ack;
    logic [WIDTH-1:0] exp_grant;
    logic             exp_valid;
    logic [IDX_W-1:0] exp_idx;
  } vec_t;

  vec_t vecs[18];

  logic [WIDTH+IDX_W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_outputs(input string name, input logic [WIDTH-1:0] g,
                               input logic v, input logic [IDX_W-1:0] i);
    check({name, ".grant"}, 32'(grant), 32'(g));
    check({name, ".valid"}, 32'(grant_valid), 32'(v));
    check({name, ".idx"}, 32'(grant_idx), 32'(i));
  endtask

  task automatic do_reset();
    req     = '0;
    ack     = 1'b0;
    lock    = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  // Reference: first requester at or after 'start' in cyclic order, -1 if none.
  function automatic int ref_pick(input logic [WIDTH-1:0] r, input int start);
    for (int k = 0; k < WIDTH; k++)
      if (r[(start + k) % WIDTH]) return (start + k) % WIDTH;
    return -1;
  endfunction

  initial begin
    int m_valid, m_idx, m_ptr, pick;
    logic [WIDTH+IDX_W:0] exp_word;

    // Reset then idle
    req = '0; ack = 1'b0; lock = 1'b0; reset_n = 1'b0;
    tick();
    check_outputs("in_reset", '0, 1'b0, '0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check_outputs("idle_after_reset", '0, 1'b0, '0);
    end

    // Directed vector table; ptr starts at 0 after each flagged reset
    vecs[0]  = '{1'b1, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[1]  = '{1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0100, 1'b1, 2'd2};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[4]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0};
    vecs[5]  = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[7]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[10] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 1'b1, 2'd3};
    vecs[11] = '{1'b0, 4'b1001, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[12] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
    vecs[14] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0};
    vecs[15] = '{1'b0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0};
    vecs[16] = '{1'b0, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
    vecs[17] = '{1'b0, 4'b0110, 1'b1, 4'b0100, 1'b1, 2'd2};
    for (int v = 0; v < 18; v++) begin
      if (vecs[v].rst) do_reset();
      req = vecs[v].req;
      ack = vecs[v].ack;
      tick();
      check_outputs($sformatf("vec%0d", v), vecs[v].exp_grant, vecs[v].exp_valid, vecs[v].exp_idx);
    end
    check("ptr_after_table", 32'(ptr_dbg), 32'd2);

    // Async reset pulse between edges while a grant is live
    do_reset();
    req = 4'b1111; ack = 1'b0;
    tick();
    req = 4'b0010; ack = 1'b1;
    tick();
    check_outputs("pre_async_reset", 4'b0010, 1'b1, 2'd1);
    ack = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_outputs("async_reset_immediate", '0, 1'b0, '0);
    check("async_reset_state", 32'(state_dbg), 32'd0);
    #2 reset_n = 1'b1;
    tick();
    check_outputs("after_async_release", 4'b0010, 1'b1, 2'd1);
    check("ptr_restart", 32'(ptr_dbg), 32'd0);

`ifdef RR_ARB_LOCK_EN
    do_reset();
    req = 4'b0011; ack = 1'b0;
    tick();
    check_outputs("lock_first", 4'b0001, 1'b1, 2'd0);
    ack = 1'b1; lock = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check_outputs("lock_hold", 4'b0001, 1'b1, 2'd0);
      check("lock_ptr", 32'(ptr_dbg), 32'd0);
    end
    lock = 1'b0;
    tick();
    check_outputs("lock_release", 4'b0010, 1'b1, 2'd1);
    ack = 1'b0;
`endif

    // Randomized traffic against the reference model
    do_reset();
    m_valid = 0; m_idx = 0; m_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      req  = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
      if ($urandom_range(0, 3) == 0) req = '0;
      ack  = 1'($urandom_range(0, 1));
      lock = 1'b0;
      if (m_valid == 0) begin
        pick = ref_pick(req, m_ptr);
        if (pick >= 0) begin m_valid = 1; m_idx = pick; end
      end else if (ack) begin
        m_ptr = (m_idx + 1) % WIDTH;
        pick  = ref_pick(req, m_ptr);
        if (pick >= 0) m_idx = pick;
        else begin m_valid = 0; m_idx = 0; end
      end
      exp_word = {1'(m_valid), IDX_W'(m_idx), m_valid ? WIDTH'(1 << m_idx) : WIDTH'(0)};
      exp_q.push_back(exp_word);
      tick();
      exp_word = exp_q.pop_front();
      check("rand_word", 32'({grant_valid, grant_idx, grant}), 32'(exp_word));
      check("rand_ptr", 32'(ptr_dbg), 32'(m_ptr));
      check("rand_onehot", 32'($onehot0(grant)), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
